// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) geometry for the serial encoder and decoder.
// Positions are 1-based; parity bits sit at powers of two.
package hamming_pkg;

  localparam int HAM_N = 15;
  localparam int HAM_K = 11;
  localparam int HAM_P = 4;

  localparam int DATA_POS [0:HAM_K-1] = '{
    3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15
  };

  typedef logic [HAM_N:1]   codeword_t;
  typedef logic [HAM_K-1:0] data_t;

endpackage

// File: rtl/hamming_correct_15_11.sv
// Combinational syndrome, single-bit correction and data extraction.
// A nonzero syndrome is the index of the bit to invert.
module hamming_correct_15_11
  import hamming_pkg::*;
(
  input  codeword_t         cw,
  output logic [HAM_P-1:0]  syndrome,
  output data_t             data,
  output logic              err
);

  logic [HAM_P-1:0] syn;
  codeword_t        fixed;

  always_comb begin
    syn = '0;
    for (int p = 1; p <= HAM_N; p++) begin
      if (cw[p]) syn = syn ^ HAM_P'(p);
    end
  end

  always_comb begin
    fixed = cw;
    for (int p = 1; p <= HAM_N; p++) begin
      fixed[p] = cw[p] ^ (syn == HAM_P'(p));
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < HAM_K; i++) begin
      data[i] = fixed[DATA_POS[i]];
    end
  end

  assign syndrome = syn;
  assign err      = |syn;

endmodule

// File: rtl/hamming_decoder_15_11.sv
// Serial Hamming(15,11) receiver: frames on a mod-15 counter,
// captures each word and decodes it one cycle later.
module hamming_decoder_15_11
  import hamming_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        din,
  output logic [10:0] data_out,
  output logic        valid,
  output logic        err,
  output logic [3:0]  syndrome
);

  logic [3:0]       cnt;
  logic [HAM_N-2:0] sr;
  codeword_t        cap;
  logic             frame_done;

  logic [HAM_P-1:0] syn_c;
  data_t            data_c;
  logic             err_c;

  hamming_correct_15_11 u_correct (
    .cw       (cap),
    .syndrome (syn_c),
    .data     (data_c),
    .err      (err_c)
  );

  // Oldest bit drifts to sr[0], so {din, sr} is position 15..1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      sr         <= '0;
      cap        <= '0;
      frame_done <= 1'b0;
      valid      <= 1'b0;
      data_out   <= '0;
      syndrome   <= '0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      valid      <= frame_done;
      if (en) begin
        sr <= {din, sr[HAM_N-2:1]};
        if (cnt == 4'd14) begin
          cnt        <= '0;
          cap        <= {din, sr};
          frame_done <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
      if (frame_done) begin
        data_out <= data_c;
        syndrome <= syn_c;
        err      <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_hamming_decoder_15_11.sv
// Directed plus randomized bench for the serial Hamming(15,11) decoder.
// Expected results come from a position-level reference model.
module tb_hamming_decoder_15_11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        din = 1'b0;
  logic [10:0] data_out;
  logic        valid;
  logic        err;
  logic [3:0]  syndrome;

  hamming_decoder_15_11 dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .din      (din),
    .data_out (data_out),
    .valid    (valid),
    .err      (err),
    .syndrome (syndrome)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int          bitcnt = 0;
  bit [15:0]   rx = '0;
  bit          done_flag = 1'b0;
  bit          st1 = 1'b0;
  bit          st2 = 1'b0;
  logic [10:0] exp_d = '0;
  logic [3:0]  exp_s = '0;
  logic        exp_e = 1'b0;
  logic [10:0] pend_d = '0;
  logic [3:0]  pend_s = '0;
  logic        pend_e = 1'b0;

  // Word bit index == code position; bit 0 unused.
  function automatic void model(
    input  bit [15:0]   w,
    output logic [10:0] d,
    output logic [3:0]  s,
    output logic        e
  );
    int syn = 0;
    int k = 0;
    bit [15:0] c = w;
    for (int p = 1; p <= 15; p++)
      if (w[p]) syn = syn ^ p;
    if (syn != 0) c[syn] = ~c[syn];
    d = '0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    end
    s = 4'(syn);
    e = (syn != 0);
  endfunction

  function automatic bit [15:0] encode(input logic [10:0] d);
    bit [15:0] w = '0;
    int k = 0;
    int syn = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[k];
        k++;
        if (w[p]) syn = syn ^ p;
      end
    end
    for (int j = 0; j < 4; j++) w[1 << j] = syn[j];
    return w;
  endfunction

  task automatic check(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] expv
  );
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit d);
    @(negedge clk);
    st2 = st1;
    st1 = done_flag;
    done_flag = 1'b0;
    if (st2) begin
      exp_d = pend_d;
      exp_s = pend_s;
      exp_e = pend_e;
    end
    check("valid", 16'(valid), 16'(st2));
    check("data_out", 16'(data_out), 16'(exp_d));
    check("syndrome", 16'(syndrome), 16'(exp_s));
    check("err", 16'(err), 16'(exp_e));
    reset = r;
    en = e;
    din = d;
    if (r) begin
      st1 = 1'b0;
      bitcnt = 0;
      exp_d = '0;
      exp_s = '0;
      exp_e = 1'b0;
    end else if (e) begin
      rx[bitcnt + 1] = d;
      if (bitcnt == 14) begin
        bitcnt = 0;
        done_flag = 1'b1;
        model(rx, pend_d, pend_s, pend_e);
      end else begin
        bitcnt++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(
    input bit [15:0] w,
    input int        gap_pct,
    input bit        gap15
  );
    for (int p = 1; p <= 15; p++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct)
        repeat (1 + $urandom_range(2)) tick(1'b0, 1'b0, 1'($urandom));
      if (p == 15 && gap15) begin
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
      end
      tick(1'b0, 1'b1, w[p]);
    end
  endtask

  initial begin
    bit [15:0] w;
    int a;
    int b;

    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);

    send_frame(encode(11'h000), 0, 1'b0);
    send_frame(encode(11'h7FF), 0, 1'b0);
    send_frame(encode(11'h001) ^ (16'h1 << 3), 0, 1'b0);
    for (int p = 1; p <= 15; p++)
      send_frame(16'hFFFE ^ (16'h1 << p), 0, 1'b0);
    send_frame(16'h0100, 0, 1'b0);
    idle(3);

    repeat (6) begin
      w = encode(11'($urandom));
      if ($urandom_range(1) == 1) w[$urandom_range(15, 1)] ^= 1'b1;
      send_frame(w, 30, 1'b1);
    end
    idle(3);

    w = encode(11'($urandom));
    for (int p = 1; p <= 7; p++) tick(1'b0, 1'b1, w[p]);
    tick(1'b1, 1'b0, 1'b0);
    idle(2);
    send_frame(encode(11'h5A3), 0, 1'b0);
    idle(3);

    repeat (3) begin
      a = $urandom_range(15, 1);
      b = 1 + (a + $urandom_range(13)) % 15;
      w = encode(11'($urandom));
      w[a] ^= 1'b1;
      w[b] ^= 1'b1;
      send_frame(w, 0, 1'b0);
    end
    idle(3);

    repeat (4) begin
      w = encode(11'($urandom));
      w[$urandom_range(15, 1)] ^= 1'b1;
      send_frame(w, 0, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_decoder_15_11.md
# hamming_decoder_15_11

Serial-input Hamming(15,11) single-error-correcting decoder, the receive-side counterpart of the 15-cycle serial encoder path. It shifts in one code bit per enabled clock and frames on a modulo-15 counter. After each 15-bit frame it computes the 4-bit syndrome, corrects a single flipped bit and presents the 11 data bits with a one-cycle valid strobe. It sits between the serial channel and the downstream data sink.

## Interface

Parameters: none. Code geometry is fixed at N=15, K=11 and is taken from the shared package.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset, sampled on the clk rising edge.
- en  in  1  sample enable; din is taken only on edges where en=1.
- din  in  1  serial code bit. The first bit of a frame is code position 1; the last is position 15.
- data_out  out  11  corrected data bits; d0 is data_out[0].
- valid  out  1  one-cycle pulse; data_out, syndrome and err are fresh in this cycle.
- err  out  1  1 when the frame's syndrome is nonzero, meaning a single error was assumed and corrected.
- syndrome  out  4  raw syndrome of the frame, equal to the failing position (1..15), or 0 if none.

## Operation

- Code layout, positions 1..15:
  - Parity bits at positions 1, 2, 4 and 8.
  - Data bits d0..d10 at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, in that order.
  - Parity bit p(2^k) gives even parity over all positions whose bit k is set.
- Bit counter cnt, 4 bits, range 0..14:
  - On an edge with en=1, din is shifted into the frame shift register and cnt increments.
  - When cnt=14 and en=1, cnt wraps to 0. The full 15-bit word (the 14 prior bits plus the current din) loads into the frame-capture register, and frame_done is raised for one cycle.
  - With en=0, cnt and the shift register hold; no bit is consumed.
- Decode stage, registered, runs on the edge after frame_done:
  - syndrome = XOR of the 4-bit indices of all positions holding 1.
  - If syndrome≠0, the bit at position syndrome is inverted.
  - The data bits are then extracted to data_out, with err = (syndrome≠0) and valid=1.
  - Because a 4-bit syndrome never exceeds 15, every nonzero value maps to a real position. A parity-bit error sets err, but data_out is unaffected.
- Double errors are not detected; they produce a miscorrection. This is accepted behaviour.
- data_out, syndrome and err hold their values between valid pulses.
- Reset:
  - cnt=0, the shift register and capture register are cleared, frame_done=0.
  - Outputs reset to data_out=0, valid=0, err=0, syndrome=0.
  - Reset mid-frame discards the partial frame; the next enabled bit is position 1.
  - Reset on the same edge as a frame_done or decode event wins: no valid pulse is produced.

## Timing

- Latency: if the position-15 bit is sampled on edge E, then on edge E+1 valid=1 and the outputs update. valid is high for exactly one cycle, between E+1 and E+2.
- Back-to-back frames with en held at 1: position 1 of the next frame is sampled on edge E+1, the same edge the decode stage fires. The capture register isolates the two, so there is no stall and no lost bit.
- The minimum spacing between valid pulses is 15 clocks.
- en may drop at any point, including on the position-15 bit. The frame completes on the enabled edge that samples position 15.
- There is no backpressure; the sink must accept data_out on every valid pulse.

## Structure

- hamming_pkg holds the following shared declarations:
  - Constants HAM_N=15, HAM_K=11 and HAM_P=4.
  - The data-position map DATA_POS[0:10] = {3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15}.
  - A codeword typedef [15:1] and a data typedef [10:0].
  - The encoder uses the same package.
- Sub-module hamming_correct_15_11 is purely combinational: 15-bit codeword in; 4-bit syndrome, corrected 11-bit data and err out. The top level holds the counter, shift register, capture register and output registers.

## Test plan

- Clean frames: send all-zero codeword (data 11'h000), then all-ones codeword 15'h7FFF (data 11'h7FF) with en=1 continuously. Expect valid once per 15 clocks, data_out=000 then 7FF, err=0, syndrome=0.
- Single data error: data 11'h001 encodes as positions 1, 2 and 3 set. Flip position 3 → syndrome=3, err=1, data_out=11'h001. Repeat by flipping each position 1..15 of 15'h7FFF → syndrome=position, data_out=7FF every time.
- Parity-bit error: all-zero frame with position 8 flipped → syndrome=8, err=1, data_out=000.
- Enable gaps: insert random en=0 cycles, including immediately before the 15th bit. Expect results identical to the gap-free run, with valid one edge after the 15th enabled sample.
- Reset mid-frame: assert reset after bit 7 of a frame. Expect outputs to clear, no valid pulse, and the next 15 enabled bits to decode as a fresh frame correctly.
- Back-to-back frames plus reset collision: run 4 consecutive frames without gaps → 4 valid pulses, 15 clocks apart. Then assert reset on the decode edge → no valid pulse and all outputs 0.
